// File: rtl/timer_pkg.sv
// Shared register map, TCON bit positions and interrupt FSM states for the
// memory-mapped timer peripheral.
package timer_pkg;

    localparam logic [1:0] TH_OFF   = 2'd0;
    localparam logic [1:0] TL_OFF   = 2'd1;
    localparam logic [1:0] TCON_OFF = 2'd2;
    localparam logic [1:0] RSV_OFF  = 2'd3;

    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int ST_BIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SVC  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Data-memory bus slice seen by the timer: load/store strobes, read data and
// the interrupt request/acknowledge pair shared with the CPU exception logic.
interface timer_irq_ctrl_if;

    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        irq_ack;

    modport master (
        output addr, rd_en, wr_en, wdata, irq_ack,
        input  rdata, irq
    );

    modport slave (
        input  addr, rd_en, wr_en, wdata, irq_ack,
        output rdata, irq
    );

endinterface

// File: rtl/timer_prescaler.sv
// Divides the system clock into one-cycle count ticks every PRESCALE clocks
// while enabled; the phase counter is held at zero whenever en is low.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer peripheral: TH/TL/TCON register window on the data bus, prescaled
// up-counting with reload on overflow, and a level IRQ with ack handshake.
//
//   state | meaning
//   IDLE  | no request; waiting for ST & IE
//   PEND  | irq asserted, waiting for the CPU to acknowledge
//   SVC   | acknowledged; waiting for software to clear ST
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    timer_irq_ctrl_if.slave  bus
);

    logic        sel;
    logic [1:0]  off;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        unused_addr_bits;

    logic [31:0] th;
    logic [31:0] tl;
    logic        en;
    logic        ie;
    logic        st;

    logic        en_run;
    logic        tick;
    logic        ovf;

    logic [31:0] rd_mux;
    logic [31:0] rdata_q;
    logic        irq_q;

    irq_state_t  state;
    irq_state_t  state_next;

    assign sel              = (bus.addr[31:4] == ADDR_BASE[31:4]);
    assign off              = bus.addr[3:2];
    assign unused_addr_bits = ^bus.addr[1:0];

    assign wr_th   = bus.wr_en && sel && (off == TH_OFF);
    assign wr_tl   = bus.wr_en && sel && (off == TL_OFF);
    assign wr_tcon = bus.wr_en && sel && (off == TCON_OFF);

    // A write clearing EN stops the prescaler on that same edge, not one later.
    assign en_run = en && !(wr_tcon && !bus.wdata[EN_BIT]);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_run),
        .tick  (tick)
    );

    assign ovf = tick && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
            tl <= '0;
            en <= 1'b0;
            ie <= 1'b0;
            st <= 1'b0;
        end else begin
            if (wr_th) begin
                th <= bus.wdata;
            end
            if (wr_tl) begin
                tl <= bus.wdata;
            end else if (tick) begin
                tl <= ovf ? th : tl + 32'd1;
            end
            if (wr_tcon) begin
                en <= bus.wdata[EN_BIT];
                ie <= bus.wdata[IE_BIT];
            end
            // A fresh overflow outranks a software clear of the sticky flag.
            if (ovf) begin
                st <= 1'b1;
            end else if (wr_tcon && !bus.wdata[ST_BIT]) begin
                st <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (sel) begin
            case (off)
                TH_OFF:   rd_mux = th;
                TL_OFF:   rd_mux = tl;
                TCON_OFF: rd_mux = {29'd0, st, ie, en};
                default:  rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (bus.rd_en) begin
            rdata_q <= rd_mux;
        end
    end

    assign bus.rdata = rdata_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (st && ie) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (bus.irq_ack) begin
                    state_next = SVC;
                end else if (!(st && ie)) begin
                    state_next = IDLE;
                end
            end
            SVC: begin
                if (!st) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            irq_q <= 1'b0;
        end else begin
            state <= state_next;
            irq_q <= (state_next == PEND);
        end
    end

    assign bus.irq = irq_q;

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Memory-mapped timer peripheral controller for the single-cycle MIPS core. Owns the TH (reload), TL (count) and TCON (control/status) registers, sequences counting with a programmable prescaler, and drives a level interrupt request with an acknowledge handshake to the CPU's exception logic. Sits on the data-memory bus alongside RAM and other peripherals and is selected by address decode.

## Interface
- ADDR_BASE, 32'h4000_0000: base of the 16-byte register window.
- PRESCALE, 1: clocks per count tick, 1..65535; 1 means a tick every clock.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the CPU data port.
- rd_en  in  1  read strobe, one cycle.
- wr_en  in  1  write strobe, one cycle.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- irq  out  1  interrupt request, level, registered.
- irq_ack  in  1  one-cycle pulse from the CPU on exception entry.

## Operation
- Select: addr[31:4]==ADDR_BASE[31:4]. Offset addr[3:2]: 0 TH, 1 TL, 2 TCON, 3 reserved (reads 0, writes ignored).
- TCON: bit0 EN, bit1 IE, bit2 ST (overflow status, sticky); bits 31:3 read 0. Write sets EN and IE; writing ST=0 clears it, writing ST=1 is ignored.
- Prescaler: counts 0..PRESCALE-1 while EN=1; tick when count==PRESCALE-1, then wraps to 0. Held at 0 while EN=0.
- On tick: TL==32'hFFFF_FFFF -> TL<=TH and ST<=1; else TL<=TL+1 (32-bit, no carry out).
- IRQ FSM, states IDLE, PEND, SVC:
  - IDLE -> PEND when ST&IE.
  - PEND -> SVC on irq_ack; PEND -> IDLE if ST or IE reads 0.
  - SVC -> IDLE when ST==0. Overflows in SVC keep ST=1 and are not re-signalled separately.
- irq = (state==PEND), registered.
- irq_ack outside PEND is ignored.
- Reset values: TH=0, TL=0, TCON=0, prescaler=0, state=IDLE, irq=0, rdata=0.

## Timing
- Writes take effect at the edge on which wr_en is sampled.
- Reads: rdata valid the cycle after rd_en, held until the next rd_en; unselected or reserved reads return 0.
- Overflow: TL reloads and ST sets on the tick edge; state enters PEND and irq rises on the following edge (1-cycle latency).
- irq falls on the edge after irq_ack is sampled in PEND.
- Simultaneous events:
  - CPU write to TL and tick in the same cycle: the write wins and the prescaler keeps counting.
  - Write to TH and overflow in the same cycle: the reload uses the old TH.
  - Software ST clear and a new overflow in the same cycle: the set wins, ST=1.
  - Write with EN=0: the prescaler zeroes at that edge; TL holds.
  - Write with EN 0->1: the first tick comes PRESCALE clocks later.
- reset asserted mid-count or mid-interrupt: all state returns to reset values immediately (async), and irq drops without waiting for a clock.

## Structure
- Package timer_pkg: register offsets (TH_OFF, TL_OFF, TCON_OFF), TCON bit indices (EN_BIT, IE_BIT, ST_BIT), IRQ FSM state enum.
- Sub-module timer_prescaler: parameter PRESCALE, inputs clk/reset/en, output tick pulse.
- Top level holds the bus decode, registers, reload arithmetic and IRQ FSM.

## Test plan
- Reset mid-run: EN=1, PEND active, reset pulled low between edges -> irq, TCON, TL read 0 immediately; rdata 0.
- PRESCALE=1, TH=32'hFFFF_FFFD, TL=32'hFFFF_FFFD, TCON=3 -> after 3 ticks TL=32'hFFFF_FFFD, ST=1; irq high 1 cycle later.
- PRESCALE=4, TL=0, EN=1 -> TL=1 after exactly 4 clocks and TL=5 after 20; writing EN=0 at clock 10 freezes TL=2.
- Handshake: irq high, irq_ack pulse -> irq low next edge, state SVC. Write TCON=3 (ST=0) -> IDLE. Second overflow -> irq again.
- Collisions: TL write in a tick cycle -> TL equals wdata. ST clear coincident with overflow -> ST reads 1. Read of offset 3 -> 0.
- IE=0 with overflow -> ST=1 and irq stays 0. Then set IE=1 -> irq rises 1 cycle after the write edge.
